// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the CPU-side memory controller.
// Covers size encodings, FSM states, the latched transfer descriptor and I/O decode.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] IO_SEL  = 2'b11;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        RESP
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        last;
        logic              fetch;
    } xfer_t;

    function automatic logic is_io(input logic [ADDR_W-1:0] addr);
        return addr[17:16] == IO_SEL;
    endfunction

    // Index of the final byte beat; size 3 is treated as a word.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IC fetches and LSB loads/stores onto the byte-wide RAM/UART bus,
// serialising each access into byte beats and reassembling reads little-endian.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_e            state_q, state_d;
    xfer_t             xfer_q, xfer_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        tag_q, tag_d;
    logic              tag_vld_q, tag_vld_d;
    logic              last_ls_q, last_ls_d;
    logic              io_gap_q, io_gap_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic [ADDR_W-1:0] beat_addr;
    logic              grant_if;
    logic              grant_ls;
    logic              issue;

    assign beat_addr = xfer_q.base + ADDR_W'(idx_q);

    // Next-state, bus drive and byte-lane assembly.
    always_comb begin
        state_d   = state_q;
        xfer_d    = xfer_q;
        idx_d     = idx_q;
        tag_d     = tag_q;
        tag_vld_d = 1'b0;
        last_ls_d = last_ls_q;
        io_gap_d  = 1'b0;
        rbuf_d    = rbuf_q;
        grant_if  = 1'b0;
        grant_ls  = 1'b0;
        issue     = 1'b0;
        mem_a     = '0;
        mem_wr    = 1'b0;
        mem_dout  = '0;

        // Capture is independent of rdy so a stall never drops a returning byte.
        if (tag_vld_q) begin
            rbuf_d[{tag_q, 3'b000} +: BYTE_W] = mem_din;
        end

        case (state_q)
            IDLE: begin
                if (rdy) begin
                    grant_if = if_req && !flush && (!ls_req || last_ls_q);
                    grant_ls = ls_req && !grant_if;
                    if (grant_if) begin
                        xfer_d.base  = if_addr;
                        xfer_d.wdata = '0;
                        xfer_d.last  = 2'd3;
                        xfer_d.fetch = 1'b1;
                        last_ls_d    = 1'b0;
                        state_d      = READ;
                    end else if (grant_ls) begin
                        xfer_d.base  = ls_addr;
                        xfer_d.wdata = ls_wdata;
                        xfer_d.last  = last_idx(ls_size);
                        xfer_d.fetch = 1'b0;
                        last_ls_d    = 1'b1;
                        state_d      = ls_we ? WRITE : READ;
                    end
                    if (grant_if || grant_ls) begin
                        idx_d  = 2'd0;
                        rbuf_d = '0;
                    end
                end
            end
            READ: begin
                if (flush && xfer_q.fetch) begin
                    state_d = IDLE;
                end else if (rdy) begin
                    mem_a     = beat_addr;
                    tag_vld_d = 1'b1;
                    tag_d     = idx_q;
                    if (idx_q == xfer_q.last) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            DRAIN: begin
                if (flush && xfer_q.fetch) begin
                    state_d = IDLE;
                end else if (rdy) begin
                    state_d = RESP;
                end
            end
            WRITE: begin
                mem_dout = xfer_q.wdata[{idx_q, 3'b000} +: BYTE_W];
                // UART beats hold for a full buffer and are spaced by a dead cycle.
                issue = rdy && !(is_io(beat_addr) && (io_buffer_full || io_gap_q));
                if (issue) begin
                    mem_a    = beat_addr;
                    mem_wr   = 1'b1;
                    io_gap_d = is_io(beat_addr);
                    if (idx_q == xfer_q.last) begin
                        state_d = RESP;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            RESP: begin
                if (rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if_done_d  = (state_d == RESP) && xfer_d.fetch;
        ls_done_d  = (state_d == RESP) && !xfer_d.fetch;
        if_data_d  = if_done_d ? rbuf_d : '0;
        ls_rdata_d = ls_done_d ? rbuf_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            xfer_q     <= '0;
            idx_q      <= '0;
            tag_q      <= '0;
            tag_vld_q  <= 1'b0;
            last_ls_q  <= 1'b1;
            io_gap_q   <= 1'b0;
            rbuf_q     <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            xfer_q     <= xfer_d;
            idx_q      <= idx_d;
            tag_q      <= tag_d;
            tag_vld_q  <= tag_vld_d;
            last_ls_q  <= last_ls_d;
            io_gap_q   <= io_gap_d;
            rbuf_q     <= rbuf_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign if_done  = if_done_q;
    assign ls_done  = ls_done_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a byte-wide RAM model returning data one cycle after the address.
// Each scenario task captures a per-cycle trace and compares it against hand-derived values.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [7:0]  ram [0:4095];
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [7:0]  bd_data;

    logic [31:0] t_a     [0:19];
    logic        t_wr    [0:19];
    logic [7:0]  t_do    [0:19];
    logic        t_ifd   [0:19];
    logic        t_lsd   [0:19];
    logic [31:0] t_ifdat [0:19];
    logic [31:0] t_lsdat [0:19];

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ls_req         (ls_req),
        .ls_we          (ls_we),
        .ls_size        (ls_size),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: backdoor preload, bus write, registered read.
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic start_cycle();
        @(posedge clk); #1;
    endtask

    // Cycle 0 is the current cycle (requests already applied at posedge+1).
    task automatic capture(input int n, input int lo_s, input int lo_n, input int iof_n, input int fl_c);
        logic if_seen;
        logic ls_seen;
        if_seen = 1'b0;
        ls_seen = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            rdy = !(c >= lo_s && c < lo_s + lo_n);
            io_buffer_full = (c < iof_n);
            if (if_seen) if_req = 1'b0;
            if (ls_seen) ls_req = 1'b0;
            flush = (c == fl_c);
            if (c == fl_c) if_req = 1'b0;
            @(negedge clk);
            t_a[c] = mem_a; t_wr[c] = mem_wr; t_do[c] = mem_dout;
            t_ifd[c] = if_done; t_lsd[c] = ls_done;
            t_ifdat[c] = if_data; t_lsdat[c] = ls_rdata;
            if_seen = if_done;
            ls_seen = ls_done;
        end
        rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        chk_cnt++; if (mem_a !== 32'h0) $display("FAIL reset_mem_a: got %h exp 00000000", mem_a); else pass_cnt++;
        chk_cnt++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr: got %b exp 0", mem_wr); else pass_cnt++;
        chk_cnt++; if (if_done !== 1'b0) $display("FAIL reset_if_done: got %b exp 0", if_done); else pass_cnt++;
        chk_cnt++; if (ls_done !== 1'b0) $display("FAIL reset_ls_done: got %b exp 0", ls_done); else pass_cnt++;
        chk_cnt++; if (if_data !== 32'h0) $display("FAIL reset_if_data: got %h exp 00000000", if_data); else pass_cnt++;
        chk_cnt++; if (ls_rdata !== 32'h0) $display("FAIL reset_ls_rdata: got %h exp 00000000", ls_rdata); else pass_cnt++;
    endtask

    task automatic test_word_fetch();
        start_cycle();
        if_addr = 32'h100; if_req = 1'b1;
        capture(8, 99, 0, 0, -1);
        chk_cnt++; if (t_a[0] !== 32'h0) $display("FAIL fetch_a0: got %h exp 00000000", t_a[0]); else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            chk_cnt++;
            if (t_a[i] !== 32'h100 + 32'(i - 1)) $display("FAIL fetch_a%0d: got %h exp %h", i, t_a[i], 32'h100 + 32'(i - 1));
            else pass_cnt++;
        end
        chk_cnt++; if (t_a[5] !== 32'h0) $display("FAIL fetch_a5: got %h exp 00000000", t_a[5]); else pass_cnt++;
        chk_cnt++; if (t_ifd[5] !== 1'b0) $display("FAIL fetch_early_done: got %b exp 0", t_ifd[5]); else pass_cnt++;
        chk_cnt++; if (t_ifd[6] !== 1'b1) $display("FAIL fetch_done6: got %b exp 1", t_ifd[6]); else pass_cnt++;
        chk_cnt++; if (t_ifdat[6] !== 32'h00500013) $display("FAIL fetch_data: got %h exp 00500013", t_ifdat[6]); else pass_cnt++;
        chk_cnt++; if (t_ifd[7] !== 1'b0) $display("FAIL fetch_done_len: got %b exp 0", t_ifd[7]); else pass_cnt++;
    endtask

    task automatic test_store_load();
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        start_cycle();
        ls_addr = 32'h200; ls_we = 1'b1; ls_size = 2'd2; ls_wdata = 32'hDEADBEEF; ls_req = 1'b1;
        capture(7, 99, 0, 0, -1);
        for (int i = 1; i <= 4; i++) begin
            chk_cnt++; if (t_wr[i] !== 1'b1) $display("FAIL store_wr%0d: got %b exp 1", i, t_wr[i]); else pass_cnt++;
            chk_cnt++;
            if (t_a[i] !== 32'h200 + 32'(i - 1)) $display("FAIL store_a%0d: got %h exp %h", i, t_a[i], 32'h200 + 32'(i - 1));
            else pass_cnt++;
            chk_cnt++; if (t_do[i] !== exp_b[i-1]) $display("FAIL store_dout%0d: got %h exp %h", i, t_do[i], exp_b[i-1]); else pass_cnt++;
        end
        chk_cnt++; if (t_wr[5] !== 1'b0) $display("FAIL store_wr5: got %b exp 0", t_wr[5]); else pass_cnt++;
        chk_cnt++; if (t_lsd[5] !== 1'b1) $display("FAIL store_done5: got %b exp 1", t_lsd[5]); else pass_cnt++;

        start_cycle();
        ls_addr = 32'h202; ls_we = 1'b0; ls_size = 2'd0; ls_req = 1'b1;
        capture(5, 99, 0, 0, -1);
        chk_cnt++; if (t_a[1] !== 32'h202) $display("FAIL ldb_a1: got %h exp 00000202", t_a[1]); else pass_cnt++;
        chk_cnt++; if (t_lsd[3] !== 1'b1) $display("FAIL ldb_done3: got %b exp 1", t_lsd[3]); else pass_cnt++;
        chk_cnt++; if (t_lsdat[3] !== 32'h000000AD) $display("FAIL ldb_data: got %h exp 000000ad", t_lsdat[3]); else pass_cnt++;
    endtask

    task automatic test_arbitration();
        start_cycle();
        if_addr = 32'h100; if_req = 1'b1;
        ls_addr = 32'h200; ls_we = 1'b0; ls_size = 2'd2; ls_req = 1'b1;
        capture(15, 99, 0, 0, -1);
        chk_cnt++; if (t_a[1] !== 32'h100) $display("FAIL arb_first_a: got %h exp 00000100", t_a[1]); else pass_cnt++;
        chk_cnt++; if (t_ifd[6] !== 1'b1) $display("FAIL arb_if_done6: got %b exp 1", t_ifd[6]); else pass_cnt++;
        chk_cnt++; if (t_ifdat[6] !== 32'h00500013) $display("FAIL arb_if_data: got %h exp 00500013", t_ifdat[6]); else pass_cnt++;
        for (int i = 5; i <= 7; i++) begin
            chk_cnt++; if (t_a[i] !== 32'h0) $display("FAIL arb_gap_a%0d: got %h exp 00000000", i, t_a[i]); else pass_cnt++;
        end
        chk_cnt++; if (t_a[8] !== 32'h200) $display("FAIL arb_second_a: got %h exp 00000200", t_a[8]); else pass_cnt++;
        chk_cnt++; if (t_lsd[13] !== 1'b1) $display("FAIL arb_ls_done13: got %b exp 1", t_lsd[13]); else pass_cnt++;
        chk_cnt++; if (t_lsdat[13] !== 32'hDEADBEEF) $display("FAIL arb_ls_data: got %h exp deadbeef", t_lsdat[13]); else pass_cnt++;
    endtask

    task automatic test_rdy_stall();
        start_cycle();
        ls_addr = 32'h100; ls_we = 1'b0; ls_size = 2'd2; ls_req = 1'b1;
        capture(11, 2, 3, 0, -1);
        for (int i = 2; i <= 4; i++) begin
            chk_cnt++; if (t_a[i] !== 32'h0) $display("FAIL stall_a%0d: got %h exp 00000000", i, t_a[i]); else pass_cnt++;
            chk_cnt++; if (t_wr[i] !== 1'b0) $display("FAIL stall_wr%0d: got %b exp 0", i, t_wr[i]); else pass_cnt++;
        end
        chk_cnt++; if (t_a[5] !== 32'h101) $display("FAIL stall_resume_a: got %h exp 00000101", t_a[5]); else pass_cnt++;
        chk_cnt++; if (t_a[7] !== 32'h103) $display("FAIL stall_last_a: got %h exp 00000103", t_a[7]); else pass_cnt++;
        chk_cnt++; if (t_lsd[8] !== 1'b0) $display("FAIL stall_early_done: got %b exp 0", t_lsd[8]); else pass_cnt++;
        chk_cnt++; if (t_lsd[9] !== 1'b1) $display("FAIL stall_done9: got %b exp 1", t_lsd[9]); else pass_cnt++;
        chk_cnt++; if (t_lsdat[9] !== 32'h00500013) $display("FAIL stall_data: got %h exp 00500013", t_lsdat[9]); else pass_cnt++;
    endtask

    task automatic test_io_store();
        int wr_n;
        start_cycle();
        ls_addr = 32'h30000; ls_we = 1'b1; ls_size = 2'd0; ls_wdata = 32'h00000041; ls_req = 1'b1;
        capture(8, 99, 0, 5, -1);
        for (int i = 1; i <= 4; i++) begin
            chk_cnt++; if (t_wr[i] !== 1'b0) $display("FAIL io_hold_wr%0d: got %b exp 0", i, t_wr[i]); else pass_cnt++;
        end
        chk_cnt++; if (t_wr[5] !== 1'b1) $display("FAIL io_wr5: got %b exp 1", t_wr[5]); else pass_cnt++;
        chk_cnt++; if (t_a[5] !== 32'h30000) $display("FAIL io_a5: got %h exp 00030000", t_a[5]); else pass_cnt++;
        chk_cnt++; if (t_do[5] !== 8'h41) $display("FAIL io_dout5: got %h exp 41", t_do[5]); else pass_cnt++;
        chk_cnt++; if (t_lsd[6] !== 1'b1) $display("FAIL io_done6: got %b exp 1", t_lsd[6]); else pass_cnt++;
        wr_n = 0;
        for (int i = 0; i < 8; i++) if (t_wr[i] === 1'b1) wr_n++;
        chk_cnt++; if (wr_n != 1) $display("FAIL io_wr_count: got %0d exp 1", wr_n); else pass_cnt++;

        start_cycle();
        ls_addr = 32'h30010; ls_we = 1'b1; ls_size = 2'd1; ls_wdata = 32'h0000BBAA; ls_req = 1'b1;
        capture(6, 99, 0, 0, -1);
        chk_cnt++; if (t_wr[1] !== 1'b1 || t_a[1] !== 32'h30010 || t_do[1] !== 8'hAA)
            $display("FAIL io_half_b0: got wr=%b a=%h d=%h exp wr=1 a=00030010 d=aa", t_wr[1], t_a[1], t_do[1]); else pass_cnt++;
        chk_cnt++; if (t_wr[2] !== 1'b0) $display("FAIL io_half_gap: got %b exp 0", t_wr[2]); else pass_cnt++;
        chk_cnt++; if (t_wr[3] !== 1'b1 || t_a[3] !== 32'h30011 || t_do[3] !== 8'hBB)
            $display("FAIL io_half_b1: got wr=%b a=%h d=%h exp wr=1 a=00030011 d=bb", t_wr[3], t_a[3], t_do[3]); else pass_cnt++;
        chk_cnt++; if (t_lsd[4] !== 1'b1) $display("FAIL io_half_done4: got %b exp 1", t_lsd[4]); else pass_cnt++;
    endtask

    task automatic test_flush();
        int done_n;
        start_cycle();
        if_addr = 32'h100; if_req = 1'b1;
        capture(10, 99, 0, 0, 3);
        chk_cnt++; if (t_a[2] !== 32'h101) $display("FAIL flush_pre_a: got %h exp 00000101", t_a[2]); else pass_cnt++;
        chk_cnt++; if (t_a[3] !== 32'h0) $display("FAIL flush_cycle_a: got %h exp 00000000", t_a[3]); else pass_cnt++;
        chk_cnt++; if (t_a[4] !== 32'h0) $display("FAIL flush_idle_a: got %h exp 00000000", t_a[4]); else pass_cnt++;
        done_n = 0;
        for (int i = 0; i < 10; i++) if (t_ifd[i] === 1'b1) done_n++;
        chk_cnt++; if (done_n != 0) $display("FAIL flush_no_done: got %0d exp 0", done_n); else pass_cnt++;

        poke(12'h000, 8'h37); poke(12'h001, 8'h12); poke(12'h002, 8'h00); poke(12'h003, 8'h00);
        start_cycle();
        if_addr = 32'h0; if_req = 1'b1;
        capture(8, 99, 0, 0, -1);
        chk_cnt++; if (t_a[4] !== 32'h3) $display("FAIL refetch_a4: got %h exp 00000003", t_a[4]); else pass_cnt++;
        chk_cnt++; if (t_ifd[6] !== 1'b1) $display("FAIL refetch_done6: got %b exp 1", t_ifd[6]); else pass_cnt++;
        chk_cnt++; if (t_ifdat[6] !== 32'h00001237) $display("FAIL refetch_data: got %h exp 00001237", t_ifdat[6]); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        poke(12'h301, 8'h00);
        start_cycle();
        ls_addr = 32'h300; ls_we = 1'b1; ls_size = 2'd2; ls_wdata = 32'h11223344; ls_req = 1'b1;
        start_cycle();
        start_cycle();
        rst = 1'b1; ls_req = 1'b0;
        #1;
        chk_cnt++; if (mem_wr !== 1'b0) $display("FAIL rstmid_wr: got %b exp 0", mem_wr); else pass_cnt++;
        chk_cnt++; if (mem_a !== 32'h0) $display("FAIL rstmid_a: got %h exp 00000000", mem_a); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        start_cycle();
        ls_addr = 32'h301; ls_we = 1'b0; ls_size = 2'd0; ls_req = 1'b1;
        capture(5, 99, 0, 0, -1);
        chk_cnt++; if (t_lsd[3] !== 1'b1) $display("FAIL rstmid_load_done: got %b exp 1", t_lsd[3]); else pass_cnt++;
        chk_cnt++; if (t_lsdat[3] !== 32'h0) $display("FAIL rstmid_partial: got %h exp 00000000", t_lsdat[3]); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
        io_buffer_full = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        test_reset();
        poke(12'h100, 8'h13); poke(12'h101, 8'h00); poke(12'h102, 8'h50); poke(12'h103, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        test_word_fetch();
        test_store_load();
        test_arbitration();
        test_rdy_stall();
        test_io_store();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
